// File: rtl/corelet_sequencer_if.sv
// corelet_sequencer_if: control and instruction-bus bundle of the corelet sequencer.
// master = tile controller (drives start/config, sees inst/status);
// slave  = the sequencer itself.
interface corelet_sequencer_if;
  logic        start;
  logic [10:0] w_base;
  logic [10:0] x_base;
  logic [10:0] p_base;
  logic [10:0] num_x;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, w_base, x_base, p_base, num_x, ofifo_valid,
    input  inst, busy, done, err
  );

  modport slave (
    input  start, w_base, x_base, p_base, num_x, ofifo_valid,
    output inst, busy, done, err
  );
endinterface

// File: rtl/corelet_sequencer.sv
// corelet_sequencer: steps one weight-stationary tile through the corelet
// instruction protocol (weights -> L0 -> array, activations -> array,
// OFIFO -> pmem, optional pmem replay through the SFP accumulator).
//
// Optional feature macro: CORELET_SEQ_ACC_EN adds the ACC replay phase.
// Without it DRAIN goes straight to DONE and inst[33] is constant 0.
//
// state   | meaning
// IDLE    | waiting for start; latches tile parameters
// RD_W    | read col weight rows from xmem, push them into L0 one cycle later
// KLOAD   | pop L0 into the array with kernel-load asserted
// KWAIT   | let the array pipeline settle (row+col cycles)
// RD_X    | read num_x activation rows from xmem into L0
// EXEC    | pop L0 into the array with execute asserted
// DRAIN   | move num_x OFIFO rows into pmem, stalling on !ofifo_valid
// ACC     | replay pmem rows through the accumulator (macro build only)
// DONE    | one-cycle done/err pulse
//
// The address map of inst fixes xmem/pmem addresses at 11 bits.
module corelet_sequencer #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int L0_DEPTH = 64
) (
  input logic                  i_clk,
  input logic                  i_reset,
  corelet_sequencer_if.slave   bus
);

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_W, S_KLOAD, S_KWAIT, S_RD_X, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_t;

  state_t      r_state;
  logic [10:0] r_cnt;       // remaining cycles (or writes) in the phase, terminal at 0
  logic [10:0] r_num;
  logic [10:0] r_x_base;
  logic [10:0] r_p_base;
  logic [10:0] r_xaddr;
  logic [10:0] r_paddr;
  logic        r_err_pend;
  logic [33:0] r_inst;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [33:0] w_inst;
  logic [10:0] w_rd_len;

  // Count at the first cycle of an xmem read phase; l0_wr lags the read by one cycle.
  assign w_rd_len = (r_state == S_RD_W) ? 11'(COL) : r_num;

  // Instruction word for the current state/counter; registered below.
  always_comb begin
    w_inst = INST_IDLE;
    case (r_state)
      S_RD_W, S_RD_X: begin
        if (r_cnt != 11'd0) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = r_xaddr;
        end
        if (r_cnt != w_rd_len) w_inst[2] = 1'b1;
      end
      S_KLOAD: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
      end
      S_EXEC: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
      end
      S_DRAIN: begin
        if (bus.ofifo_valid) begin
          w_inst[6]     = 1'b1;
          w_inst[32]    = 1'b0;
          w_inst[31]    = 1'b0;
          w_inst[30:20] = r_paddr;
        end
      end
`ifdef CORELET_SEQ_ACC_EN
      S_ACC: begin
        if (r_cnt != 11'd0) begin
          w_inst[32]    = 1'b0;
          w_inst[30:20] = r_paddr;
        end
        if (r_cnt != r_num) w_inst[33] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer FSM, phase counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_num      <= '0;
      r_x_base   <= '0;
      r_p_base   <= '0;
      r_xaddr    <= '0;
      r_paddr    <= '0;
      r_err_pend <= 1'b0;
      r_inst     <= INST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inst <= w_inst;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= bus.start;
          if (bus.start) begin
            r_num      <= bus.num_x;
            r_x_base   <= bus.x_base;
            r_p_base   <= bus.p_base;
            r_xaddr    <= bus.w_base;
            r_cnt      <= 11'(COL);
            r_err_pend <= (bus.num_x > 11'(L0_DEPTH));
            if (bus.num_x == 11'd0 || bus.num_x > 11'(L0_DEPTH)) r_state <= S_DONE;
            else                                                 r_state <= S_RD_W;
          end
        end
        S_RD_W: begin
          r_xaddr <= r_xaddr + 11'd1;
          if (r_cnt == 11'd0) begin
            r_state <= S_KLOAD;
            r_cnt   <= 11'(COL - 1);
          end else r_cnt <= r_cnt - 11'd1;
        end
        S_KLOAD: begin
          if (r_cnt == 11'd0) begin
            r_state <= S_KWAIT;
            r_cnt   <= 11'(ROW + COL - 1);
          end else r_cnt <= r_cnt - 11'd1;
        end
        S_KWAIT: begin
          if (r_cnt == 11'd0) begin
            r_state <= S_RD_X;
            r_cnt   <= r_num;
            r_xaddr <= r_x_base;
          end else r_cnt <= r_cnt - 11'd1;
        end
        S_RD_X: begin
          r_xaddr <= r_xaddr + 11'd1;
          if (r_cnt == 11'd0) begin
            r_state <= S_EXEC;
            r_cnt   <= r_num - 11'd1;
          end else r_cnt <= r_cnt - 11'd1;
        end
        S_EXEC: begin
          if (r_cnt == 11'd0) begin
            r_state <= S_DRAIN;
            r_cnt   <= r_num - 11'd1;
            r_paddr <= r_p_base;
          end else r_cnt <= r_cnt - 11'd1;
        end
        S_DRAIN: begin
          if (bus.ofifo_valid) begin
            r_paddr <= r_paddr + 11'd1;
            if (r_cnt == 11'd0) begin
`ifdef CORELET_SEQ_ACC_EN
              r_state <= S_ACC;
              r_cnt   <= r_num;
              r_paddr <= r_p_base;
`else
              r_state <= S_DONE;
`endif
            end else r_cnt <= r_cnt - 11'd1;
          end
        end
`ifdef CORELET_SEQ_ACC_EN
        S_ACC: begin
          r_paddr <= r_paddr + 11'd1;
          if (r_cnt == 11'd0) r_state <= S_DONE;
          else                r_cnt   <= r_cnt - 11'd1;
        end
`endif
        S_DONE: begin
          r_done  <= 1'b1;
          r_err   <= r_err_pend;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst = r_inst;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_corelet_sequencer.sv
// tb_corelet_sequencer: scenario tasks for corelet_sequencer. Each tile's
// inst/done/busy/err trace (index 0 = the edge that samples start) is compared
// with a phase-by-phase model built from the protocol rules and the recorded
// ofifo_valid pattern.
module tb_corelet_sequencer;
  localparam int ROW = 8, COL = 8, L0_DEPTH = 64;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  corelet_sequencer_if bus();
  corelet_sequencer #(.ROW(ROW), .COL(COL), .L0_DEPTH(L0_DEPTH)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [33:0] tr_inst[$];
  bit          tr_done[$];
  bit          tr_busy[$];
  bit          tr_err[$];
  bit          vld[$];
  logic [33:0] ex_inst[$];
  int          ex_done_idx;
  bit          ex_err;
  logic [33:0] d_exp;
  logic [33:0] d_got;

  function automatic bit pick_vld(int vmode, int t);
    if (vmode == 0) return 1'b1;
    if (vmode == 1) return (t % 2 == 1);
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic int tile_len(int n);
    int l;
    if (n == 0 || n > L0_DEPTH) return 1;
    l = (COL + 1) + COL + (ROW + COL) + (n + 1) + n + n + 1;
`ifdef CORELET_SEQ_ACC_EN
    l += n + 1;
`endif
    return l;
  endfunction

  task automatic sample();
    tr_inst.push_back(bus.inst);
    tr_done.push_back(bus.done === 1'b1);
    tr_busy.push_back(bus.busy === 1'b1);
    tr_err.push_back(bus.err === 1'b1);
  endtask

  // Runs one tile and records the trace up to one cycle after done.
  task automatic run_tile(input logic [10:0] w, x, p, n, input int vmode, input int extra_start);
    bit v;
    bit seen;
    tr_inst.delete(); tr_done.delete(); tr_busy.delete(); tr_err.delete(); vld.delete();
    @(negedge clk);
    bus.w_base = w; bus.x_base = x; bus.p_base = p; bus.num_x = n;
    bus.start = 1'b1;
    v = pick_vld(vmode, 0); bus.ofifo_valid = v; vld.push_back(v);
    @(posedge clk); #1 sample();
    seen = 1'b0;
    for (int k = 1; k < 600; k++) begin
      @(negedge clk);
      bus.start  = (k == extra_start);
      bus.w_base = 11'($urandom); bus.x_base = 11'($urandom);
      bus.p_base = 11'($urandom); bus.num_x  = 11'($urandom);
      v = pick_vld(vmode, k); bus.ofifo_valid = v; vld.push_back(v);
      @(posedge clk); #1 sample();
      if (seen) break;
      if (tr_done[k]) seen = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  // Expected inst stream from the phase rules; DRAIN follows the recorded valid pattern.
  task automatic build_model(input logic [10:0] w, x, p, input int n);
    logic [33:0] v;
    int j;
    int t;
    ex_inst.delete();
    ex_inst.push_back(IDLE);
    ex_err = (n > L0_DEPTH);
    if (n != 0 && n <= L0_DEPTH) begin
      for (int k = 0; k <= COL; k++) begin
        v = IDLE;
        if (k < COL) begin v[19] = 1'b0; v[17:7] = w + 11'(k); end
        if (k >= 1) v[2] = 1'b1;
        ex_inst.push_back(v);
      end
      for (int k = 0; k < COL; k++) begin
        v = IDLE; v[3] = 1'b1; v[0] = 1'b1; ex_inst.push_back(v);
      end
      for (int k = 0; k < ROW + COL; k++) ex_inst.push_back(IDLE);
      for (int k = 0; k <= n; k++) begin
        v = IDLE;
        if (k < n) begin v[19] = 1'b0; v[17:7] = x + 11'(k); end
        if (k >= 1) v[2] = 1'b1;
        ex_inst.push_back(v);
      end
      for (int k = 0; k < n; k++) begin
        v = IDLE; v[3] = 1'b1; v[1] = 1'b1; ex_inst.push_back(v);
      end
      j = 0;
      while (j < n) begin
        t = ex_inst.size();
        if (t >= vld.size()) break;
        v = IDLE;
        if (vld[t]) begin
          v[6] = 1'b1; v[32] = 1'b0; v[31] = 1'b0; v[30:20] = p + 11'(j);
          j++;
        end
        ex_inst.push_back(v);
      end
`ifdef CORELET_SEQ_ACC_EN
      for (int k = 0; k <= n; k++) begin
        v = IDLE;
        if (k < n) begin v[32] = 1'b0; v[30:20] = p + 11'(k); end
        if (k >= 1) v[33] = 1'b1;
        ex_inst.push_back(v);
      end
`endif
    end
    ex_inst.push_back(IDLE);
    ex_done_idx = ex_inst.size() - 1;
  endtask

  // First trace index disagreeing with the model (-1 when the whole trace agrees).
  function automatic int trace_diff();
    logic [33:0] e;
    for (int i = 0; i <= ex_done_idx + 1; i++) begin
      e = (i < ex_inst.size()) ? ex_inst[i] : IDLE;
      d_exp = e;
      d_got = (i < tr_inst.size()) ? tr_inst[i] : 34'h0;
      if (i >= tr_inst.size()) return i;
      if (tr_inst[i] !== e) return i;
      if (tr_done[i] != (i == ex_done_idx)) return i;
      if (tr_busy[i] != (i <= ex_done_idx)) return i;
      if (tr_err[i] != ((i == ex_done_idx) && ex_err)) return i;
    end
    return -1;
  endfunction

  function automatic int first_done();
    foreach (tr_done[i]) if (tr_done[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.ofifo_valid = 1'b0;
    bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.num_x = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.inst !== IDLE) begin bad++; $display("FAIL reset_inst got=%h exp=%h", bus.inst, IDLE); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.err  !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nominal();
    int d, fk, nl0, nk, ne, nbad;
    logic [10:0] a[$];
    run_tile(11'd0, 11'd8, 11'd0, 11'd36, 0, -1);
    build_model(11'd0, 11'd8, 11'd0, 36);
    d = trace_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL nominal_trace idx=%0d got=%h exp=%h", d, d_got, d_exp); end
    total++; if (first_done() !== tile_len(36)) begin bad++; $display("FAIL nominal_latency got=%0d exp=%0d", first_done(), tile_len(36)); end
    fk = -1; nl0 = 0; nk = 0; ne = 0;
    foreach (tr_inst[i]) begin
      if (tr_inst[i][0] && fk < 0) fk = i;
      if (tr_inst[i][2] && fk < 0) nl0++;
      if (tr_inst[i][0]) nk++;
      if (tr_inst[i][1]) ne++;
      if (!tr_inst[i][32] && !tr_inst[i][31]) a.push_back(tr_inst[i][30:20]);
    end
    total++; if (nl0 !== COL) begin bad++; $display("FAIL nominal_l0wr_before_kload got=%0d exp=%0d", nl0, COL); end
    total++; if (nk !== COL) begin bad++; $display("FAIL nominal_kload got=%0d exp=%0d", nk, COL); end
    total++; if (ne !== 36) begin bad++; $display("FAIL nominal_exec got=%0d exp=36", ne); end
    nbad = 0;
    foreach (a[i]) if (a[i] !== 11'(i)) nbad++;
    total++; if (a.size() !== 36 || nbad !== 0) begin bad++; $display("FAIL nominal_pmem_wr count=%0d badaddr=%0d exp count=36 badaddr=0", a.size(), nbad); end
  endtask

  task automatic test_stall_toggle();
    int d, nbad;
    logic [10:0] a[$];
    run_tile(11'd0, 11'd8, 11'd0, 11'd36, 1, -1);
    build_model(11'd0, 11'd8, 11'd0, 36);
    d = trace_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL stall_trace idx=%0d got=%h exp=%h", d, d_got, d_exp); end
    total++; if (first_done() !== tile_len(36) + 35) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", first_done(), tile_len(36) + 35); end
    foreach (tr_inst[i]) if (!tr_inst[i][32] && !tr_inst[i][31]) a.push_back(tr_inst[i][30:20]);
    nbad = 0;
    foreach (a[i]) if (a[i] !== 11'(i)) nbad++;
    total++; if (a.size() !== 36 || nbad !== 0) begin bad++; $display("FAIL stall_pmem_wr count=%0d badaddr=%0d exp count=36 badaddr=0", a.size(), nbad); end
  endtask

  task automatic test_reject();
    int nlist[2] = '{0, 65};
    int d, nonidle;
    foreach (nlist[m]) begin
      run_tile(11'd3, 11'd9, 11'd5, 11'(nlist[m]), 0, -1);
      build_model(11'd3, 11'd9, 11'd5, nlist[m]);
      d = trace_diff();
      total++; if (d !== -1) begin bad++; $display("FAIL reject_trace n=%0d idx=%0d got=%h exp=%h", nlist[m], d, d_got, d_exp); end
      total++; if (first_done() !== 1) begin bad++; $display("FAIL reject_done_idx n=%0d got=%0d exp=1", nlist[m], first_done()); end
      total++; if (tr_err[1] !== (nlist[m] > L0_DEPTH)) begin bad++; $display("FAIL reject_err n=%0d got=%b exp=%b", nlist[m], tr_err[1], nlist[m] > L0_DEPTH); end
      nonidle = 0;
      foreach (tr_inst[i]) if (tr_inst[i] !== IDLE) nonidle++;
      total++; if (nonidle !== 0) begin bad++; $display("FAIL reject_inst_idle n=%0d nonidle=%0d exp=0", nlist[m], nonidle); end
    end
  endtask

  task automatic test_wrap();
    int d;
    logic [10:0] a[$];
    logic [10:0] e[4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    run_tile(11'h7FC, 11'h7FD, 11'h7FE, 11'd4, 0, -1);
    build_model(11'h7FC, 11'h7FD, 11'h7FE, 4);
    d = trace_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL wrap_trace idx=%0d got=%h exp=%h", d, d_got, d_exp); end
    foreach (tr_inst[i]) if (!tr_inst[i][32] && !tr_inst[i][31]) a.push_back(tr_inst[i][30:20]);
    total++; if (a.size() !== 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", a.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (a[i] !== e[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, a[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid_exec();
    int d;
    logic [33:0] pre;
    @(negedge clk);
    bus.w_base = 11'd0; bus.x_base = 11'd8; bus.p_base = 11'd0; bus.num_x = 11'd36;
    bus.start = 1'b1; bus.ofifo_valid = 1'b1;
    @(posedge clk);
    pre = IDLE;
    for (int k = 1; k < 80; k++) begin
      @(negedge clk); bus.start = 1'b0;
      @(posedge clk); #1 pre = bus.inst;
    end
    total++; if (pre[1] !== 1'b1) begin bad++; $display("FAIL rst_exec_active got=%b exp=1", pre[1]); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.inst !== IDLE) begin bad++; $display("FAIL rst_exec_inst got=%h exp=%h", bus.inst, IDLE); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_exec_busy got=%b exp=0", bus.busy); end
    @(negedge clk); rst = 1'b0;
    run_tile(11'd40, 11'd100, 11'd200, 11'd12, 2, -1);
    build_model(11'd40, 11'd100, 11'd200, 12);
    d = trace_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL rst_exec_retile idx=%0d got=%h exp=%h", d, d_got, d_exp); end
  endtask

  task automatic test_acc();
    int d, nacc, nbad;
    int ridx[$];
    logic [10:0] raddr[$];
    run_tile(11'd0, 11'd8, 11'd0, 11'd4, 0, -1);
    build_model(11'd0, 11'd8, 11'd0, 4);
    d = trace_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL acc_trace idx=%0d got=%h exp=%h", d, d_got, d_exp); end
    nacc = 0; nbad = 0;
    foreach (tr_inst[i]) begin
      if (!tr_inst[i][32] && tr_inst[i][31]) begin ridx.push_back(i); raddr.push_back(tr_inst[i][30:20]); end
      if (tr_inst[i][33]) nacc++;
    end
`ifdef CORELET_SEQ_ACC_EN
    foreach (ridx[i]) begin
      if (raddr[i] !== 11'(i)) nbad++;
      if (ridx[i] + 1 >= tr_inst.size() || !tr_inst[ridx[i] + 1][33]) nbad++;
    end
    total++; if (ridx.size() !== 4 || nacc !== 4 || nbad !== 0) begin bad++; $display("FAIL acc_replay reads=%0d acc=%0d bad=%0d exp reads=4 acc=4 bad=0", ridx.size(), nacc, nbad); end
`else
    total++; if (ridx.size() !== 0 || nacc !== 0) begin bad++; $display("FAIL acc_absent reads=%0d acc=%0d exp 0 0", ridx.size(), nacc); end
`endif
  endtask

  task automatic test_random();
    int d, n, nw;
    logic [10:0] w, x, p;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 1 : (it == 1) ? L0_DEPTH : int'($urandom_range(2, L0_DEPTH - 1));
      w = 11'($urandom); x = 11'($urandom); p = 11'($urandom);
      run_tile(w, x, p, 11'(n), 2, 15);
      build_model(w, x, p, n);
      d = trace_diff();
      total++; if (d !== -1) begin bad++; $display("FAIL random_trace it=%0d n=%0d idx=%0d got=%h exp=%h", it, n, d, d_got, d_exp); end
      nw = 0;
      foreach (tr_inst[i]) if (!tr_inst[i][32] && !tr_inst[i][31]) nw++;
      total++; if (nw !== n) begin bad++; $display("FAIL random_wr_count it=%0d got=%0d exp=%0d", it, nw, n); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.ofifo_valid = 1'b0;
    bus.w_base = '0; bus.x_base = '0; bus.p_base = '0; bus.num_x = '0;
    test_reset();
    test_nominal();
    test_stall_toggle();
    test_reject();
    test_wrap();
    test_reset_mid_exec();
    test_acc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
